// File: rtl/key_conditioner.sv
// Debounces a bank of raw key inputs into stable levels, press/release pulses and a priority note code.
// Optional KEY_SYNC_EN inserts a 2-flop synchronizer on every raw key bit ahead of the debouncer.
module key_conditioner #(
  parameter int N_KEYS          = 7,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [3:0]        note,
  output logic              note_valid,
  output logic              multi_press
);

  typedef enum logic {STABLE, CHANGING} key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sampled;

`ifdef KEY_SYNC_EN
  logic [N_KEYS-1:0] sync1_reg;
  logic [N_KEYS-1:0] sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= keys_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign sampled = sync2_reg;
`else
  assign sampled = keys_raw;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_state_t       state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_reg;
      logic             press_reg;
      logic             release_reg;

      // The first differing sample already counts as cycle one of the window.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg   <= STABLE;
          cnt_reg     <= '0;
          stable_reg  <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          case (state_reg)
            STABLE: begin
              cnt_reg <= '0;
              if (sampled[gi] != stable_reg) begin
                state_reg <= CHANGING;
                cnt_reg   <= CNT_W'(1);
              end
            end
            CHANGING: begin
              if (sampled[gi] == stable_reg) begin
                state_reg <= STABLE;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg   <= STABLE;
                cnt_reg     <= '0;
                stable_reg  <= ~stable_reg;
                press_reg   <= ~stable_reg;
                release_reg <= stable_reg;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end
            default: begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end
          endcase
        end
      end

      assign keys_stable[gi] = stable_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
    end
  endgenerate

  // Scan from the top down so the lowest set key is the last to overwrite note.
  always_comb begin
    note = 4'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (keys_stable[i]) note = 4'(i + 1);
    end
  end

  assign note_valid  = |keys_stable;
  assign multi_press = |(keys_stable & (keys_stable - N_KEYS'(1)));

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4; latency follows KEY_SYNC_EN.
module tb_key_conditioner;

`ifdef KEY_SYNC_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] keys_raw;
  logic [6:0] keys_stable;
  logic [6:0] key_press;
  logic [6:0] key_release;
  logic [3:0] note;
  logic       note_valid;
  logic       multi_press;

  int n_cmp = 0;
  int n_err = 0;

  key_conditioner #(.N_KEYS(7), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .keys_raw    (keys_raw),
    .keys_stable (keys_stable),
    .key_press   (key_press),
    .key_release (key_release),
    .note        (note),
    .note_valid  (note_valid),
    .multi_press (multi_press)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".stable"},  32'(keys_stable), 32'h0);
    check({tag, ".press"},   32'(key_press),   32'h0);
    check({tag, ".release"}, 32'(key_release), 32'h0);
    check({tag, ".note"},    32'(note),        32'h0);
    check({tag, ".valid"},   32'(note_valid),  32'h0);
    check({tag, ".multi"},   32'(multi_press), 32'h0);
  endtask

  int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
  int n_press;
  int press_at;

  initial begin
    // 1: all keys held through reset
    reset    = 1'b1;
    keys_raw = 7'h7F;
    tick(2);
    check_idle("s1_rst");
    reset = 1'b0;
    tick(LAT - 1);
    check("s1_early.stable", 32'(keys_stable), 32'h00);
    tick(1);
    check("s1.stable", 32'(keys_stable), 32'h7F);
    check("s1.press",  32'(key_press),   32'h7F);
    check("s1.note",   32'(note),        32'd1);
    check("s1.multi",  32'(multi_press), 32'h1);
    tick(1);
    check("s1.press_end", 32'(key_press), 32'h00);
    keys_raw = 7'h00;
    tick(LAT);
    check("s1.release", 32'(key_release), 32'h7F);
    check("s1.note0",   32'(note),        32'd0);
    tick(1);

    // 2: clean press and release of key 2
    keys_raw = 7'h04;
    tick(LAT - 1);
    check("s2_early.press", 32'(key_press), 32'h00);
    tick(1);
    check("s2.stable", 32'(keys_stable), 32'h04);
    check("s2.press",  32'(key_press),   32'h04);
    check("s2.note",   32'(note),        32'd3);
    check("s2.valid",  32'(note_valid),  32'h1);
    check("s2.multi",  32'(multi_press), 32'h0);
    keys_raw = 7'h00;
    tick(LAT - 1);
    check("s2_early.release", 32'(key_release), 32'h00);
    check("s2_early.stable",  32'(keys_stable), 32'h04);
    tick(1);
    check("s2.release", 32'(key_release), 32'h04);
    check("s2.note0",   32'(note),        32'd0);
    check("s2.valid0",  32'(note_valid),  32'h0);
    tick(1);

    // 3: bounce on key 0 restarts the window
    n_press  = 0;
    press_at = 0;
    for (int i = 0; i < 12; i++) begin
      keys_raw[0] = (i < 8) ? pat[i][0] : 1'b1;
      tick(1);
      if (key_press[0]) begin
        n_press++;
        press_at = i + 1;
      end
    end
    check("s3.n_press",  32'(n_press),     32'd1);
    check("s3.press_at", 32'(press_at),    32'(LAT + 4));
    check("s3.stable",   32'(keys_stable), 32'h01);
    keys_raw = 7'h00;
    tick(LAT + 1);

    // 4: two keys together, then release the lower one
    keys_raw = 7'b0010100;
    tick(LAT);
    check("s4.press", 32'(key_press),   32'h14);
    check("s4.note",  32'(note),        32'd3);
    check("s4.multi", 32'(multi_press), 32'h1);
    keys_raw = 7'b0010000;
    tick(LAT);
    check("s4.release", 32'(key_release), 32'h04);
    check("s4.note5",   32'(note),        32'd5);
    check("s4.multi0",  32'(multi_press), 32'h0);
    check("s4.valid",   32'(note_valid),  32'h1);
    keys_raw = 7'h00;
    tick(LAT + 1);

    // 5: reset lands mid-qualification of key 6 while key 0 is stable
    keys_raw = 7'h01;
    tick(LAT + 1);
    check("s5_pre.stable", 32'(keys_stable), 32'h01);
    keys_raw = 7'h41;
    tick(2);
    reset = 1'b1;
    #1;
    check_idle("s5_async");
    tick(1);
    check("s5_held.stable", 32'(keys_stable), 32'h00);
    reset = 1'b0;
    tick(LAT - 1);
    check("s5_early.press", 32'(key_press), 32'h00);
    tick(1);
    check("s5.press",  32'(key_press),   32'h41);
    check("s5.stable", 32'(keys_stable), 32'h41);
    check("s5.note",   32'(note),        32'd1);
    tick(1);
    check("s5.press_end", 32'(key_press), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
